cmem_pp: RTL and testbench

Parametrised, double-buffered coefficient memory for the FIR core. Provides `NBANK` independent registered read ports (one per tap group), each reading `WIDTH`-bit coefficients from its own `DEPTH`-word bank. A single streaming write port fills a shadow coefficient set sequentially while the datapath keeps reading the active set. A `swap` request then atomically exchanges the two sets, so coefficient reloads happen without stalling the filter.

---
 rtl/cmem_pkg.sv | 29 ++
 rtl/cmem_bank.sv | 41 ++++
 rtl/cmem_pp.sv | 111 +++++++++++
 tb/tb_cmem_pp.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cmem_pkg.sv
// cmem_pkg: shared defaults, enable encodings and pointer helper
// for the double-buffered FIR coefficient memory.
package cmem_pkg;

   localparam int CMEM_NBANK = 8;
   localparam int CMEM_DEPTH = 64;
   localparam int CMEM_WIDTH = 16;

   // Active-low enable encodings
   localparam logic ON  = 1'b0;
   localparam logic OFF = 1'b1;

   typedef struct packed {
      logic [15:0] bank;
      logic [15:0] word;
   } wsplit_t;

   // Split a linear fill pointer into bank index and word offset
   function automatic wsplit_t wptr_split(
      input logic [31:0] wptr,
      input int unsigned depth
   );
      wsplit_t s;
      s.bank = 16'(wptr / depth);
      s.word = 16'(wptr % depth);
      return s;
   endfunction

endpackage

// File: rtl/cmem_bank.sv
// cmem_bank: one coefficient bank holding two sets of DEPTH words.
// Ports: clk/rst, write (we_i, wset_i, waddr_i, wdata_i),
//        registered read (re_i, rset_i, raddr_i, q_o).
module cmem_bank #(
   parameter  int DEPTH = 64,
   parameter  int WIDTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we_i,
   input  logic             wset_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic             rset_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] mem_q [2*DEPTH];
   logic [WIDTH-1:0] q_q;

   // Storage is deliberately not reset
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[{wset_i, waddr_i}] <= wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else if (re_i) begin
         q_q <= mem_q[{rset_i, raddr_i}];
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/cmem_pp.sv
// cmem_pp: double-buffered coefficient memory, NBANK read ports.
// Ports: clk, rst, CEN/WEN (active-low), D (stream write), A/Q (reads),
//        swap, restart, load_full, active_set.
module cmem_pp
   import cmem_pkg::*;
#(
   parameter  int NBANK = CMEM_NBANK,
   parameter  int DEPTH = CMEM_DEPTH,
   parameter  int WIDTH = CMEM_WIDTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   CEN,
   input  logic                   WEN,
   input  logic [WIDTH-1:0]       D,
   input  logic [NBANK*AW-1:0]    A,
   output logic [NBANK*WIDTH-1:0] Q,
   input  logic                   swap,
   input  logic                   restart,
   output logic                   load_full,
   output logic                   active_set
);

   localparam int NW = NBANK * DEPTH;
   localparam int PW = $clog2(NW);
   localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;

   logic [PW-1:0] wptr_q, wptr_d;
   logic          full_q, full_d;
   logic          set_q, set_d;

   logic          rd_en;
   logic          wr_req;
   logic          swap_go;
   logic          wr_go;

   wsplit_t       wsp;
   logic [BW-1:0] wr_bank;
   logic [AW-1:0] wr_word;
   logic          unused_split;

   assign wsp     = wptr_split(32'(wptr_q), DEPTH);
   assign wr_bank = wsp.bank[BW-1:0];
   assign wr_word = wsp.word[AW-1:0];
   assign unused_split = ^{wsp.bank[15:BW], wsp.word[15:AW]};

   assign rd_en   = (CEN == ON);
   assign wr_req  = rd_en && (WEN == ON) && !full_q;
   assign swap_go = swap && full_q;
   // Swap and restart both rewind the pointer, so a write there is lost
   assign wr_go   = wr_req && !swap_go && !restart && !rst;

   always_comb begin
      wptr_d = wptr_q;
      full_d = full_q;
      set_d  = set_q;
      if (swap_go) begin
         set_d  = ~set_q;
         full_d = 1'b0;
         wptr_d = '0;
      end else if (restart) begin
         full_d = 1'b0;
         wptr_d = '0;
      end else if (wr_go) begin
         if (wptr_q == PW'(NW - 1)) begin
            wptr_d = '0;
            full_d = 1'b1;
         end else begin
            wptr_d = wptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         full_q <= 1'b0;
         set_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         full_q <= full_d;
         set_q  <= set_d;
      end
   end

   for (genvar k = 0; k < NBANK; k++) begin : g_bank
      logic bank_we;
      assign bank_we = wr_go && (wr_bank == BW'(k));

      cmem_bank #(
         .DEPTH (DEPTH),
         .WIDTH (WIDTH)
      ) u_bank (
         .clk     (clk),
         .rst     (rst),
         .we_i    (bank_we),
         .wset_i  (~set_q),
         .waddr_i (wr_word),
         .wdata_i (D),
         .re_i    (rd_en),
         .rset_i  (set_q),
         .raddr_i (A[k*AW +: AW]),
         .q_o     (Q[k*WIDTH +: WIDTH])
      );
   end

   assign load_full  = full_q;
   assign active_set = set_q;

endmodule

// File: tb/tb_cmem_pp.sv
// tb_cmem_pp: directed self-checking bench for cmem_pp
// (8 banks x 64 words x 16 bits).
module tb_cmem_pp;
   import cmem_pkg::*;

   localparam int NB = 8;
   localparam int DP = 64;
   localparam int WD = 16;
   localparam int AW = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             CEN;
   logic             WEN;
   logic [WD-1:0]    D;
   logic [NB*AW-1:0] A;
   logic [NB*WD-1:0] Q;
   logic             swap;
   logic             restart;
   logic             load_full;
   logic             active_set;

   int checks = 0;
   int errors = 0;

   logic [AW-1:0]    ja [NB];
   logic [NB*WD-1:0] hold_q;

   cmem_pp dut (
      .clk        (clk),
      .rst        (rst),
      .CEN        (CEN),
      .WEN        (WEN),
      .D          (D),
      .A          (A),
      .Q          (Q),
      .swap       (swap),
      .restart    (restart),
      .load_full  (load_full),
      .active_set (active_set)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(
      input string            tag,
      input logic [NB*WD-1:0] got,
      input logic [NB*WD-1:0] exp
   );
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic load(
      input int          n,
      input int          start,
      input logic [15:0] base,
      input bit          incr
   );
      for (int i = 0; i < n; i++) begin
         CEN = ON;
         WEN = ON;
         D   = incr ? 16'(base + 16'(start + i)) : base;
         tick();
      end
      WEN = OFF;
   endtask

   task automatic drive_a();
      for (int k = 0; k < NB; k++) A[k*AW +: AW] = ja[k];
   endtask

   task automatic all_a(input int j);
      for (int k = 0; k < NB; k++) ja[k] = AW'(j);
      drive_a();
   endtask

   function automatic logic [NB*WD-1:0] expq(input logic [15:0] base);
      logic [NB*WD-1:0] r;
      for (int k = 0; k < NB; k++)
         r[k*WD +: WD] = 16'(base + 16'(k * DP) + 16'(ja[k]));
      return r;
   endfunction

   task automatic pulse_swap();
      swap = 1'b1;
      tick();
      swap = 1'b0;
   endtask

   initial begin
      rst = 1'b1; CEN = OFF; WEN = OFF; D = '0; A = '0;
      swap = 1'b0; restart = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check_eq("rst_q", Q, '0);
      check_eq("rst_set", 128'(active_set), 128'(0));
      check_eq("rst_full", 128'(load_full), 128'(0));

      // Fill set 1 with D=i
      load(511, 0, 16'h0000, 1'b1);
      check_eq("full_511", 128'(load_full), 128'(0));
      load(1, 511, 16'h0000, 1'b1);
      check_eq("full_512", 128'(load_full), 128'(1));
      pulse_swap();
      check_eq("swap1_set", 128'(active_set), 128'(1));
      check_eq("swap1_full", 128'(load_full), 128'(0));

      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < NB; k++) ja[k] = AW'($urandom_range(0, 63));
         drive_a();
         CEN = ON;
         tick();
         check_eq("rd_set1", Q, expq(16'h0000));
      end

      // Concurrent load of set 0 while reading set 1
      for (int k = 0; k < NB; k++) ja[k] = AW'(k + 3);
      drive_a();
      tick();
      load(256, 0, 16'hA000, 1'b1);
      check_eq("conc_mid", Q, expq(16'h0000));
      load(256, 256, 16'hA000, 1'b1);
      check_eq("conc_end", Q, expq(16'h0000));
      check_eq("conc_full", 128'(load_full), 128'(1));
      load(5, 0, 16'hFFFF, 1'b0);
      check_eq("ovf_full", 128'(load_full), 128'(1));
      swap = 1'b1;
      tick();
      swap = 1'b0;
      check_eq("swapedge_q", Q, expq(16'h0000));
      check_eq("swap2_set", 128'(active_set), 128'(0));
      tick();
      check_eq("after_swap_q", Q, expq(16'hA000));
      all_a(0);
      tick();
      check_eq("ovf_w0", Q, expq(16'hA000));
      all_a(63);
      tick();
      check_eq("ovf_w63", Q, expq(16'hA000));

      // Early swap is ignored
      load(100, 0, 16'h1234, 1'b0);
      pulse_swap();
      check_eq("early_set", 128'(active_set), 128'(0));
      check_eq("early_full", 128'(load_full), 128'(0));

      // Restart with a coincident write that must be dropped
      restart = 1'b1; CEN = ON; WEN = ON; D = 16'hDEAD;
      tick();
      restart = 1'b0; WEN = OFF;
      check_eq("rs_set", 128'(active_set), 128'(0));
      load(511, 0, 16'h5555, 1'b0);
      check_eq("rs_full_511", 128'(load_full), 128'(0));
      load(1, 0, 16'h5555, 1'b0);
      check_eq("rs_full_512", 128'(load_full), 128'(1));
      pulse_swap();
      check_eq("rs_swap_set", 128'(active_set), 128'(1));
      for (int j = 0; j < DP; j++) begin
         all_a(j);
         tick();
         check_eq("rs_all", Q, {NB{16'h5555}});
      end

      // CEN high blocks writes
      CEN = OFF; WEN = ON; D = 16'h0BAD;
      for (int i = 0; i < 10; i++) tick();
      WEN = OFF;
      check_eq("cen_nowr", 128'(load_full), 128'(0));
      load(511, 0, 16'h7000, 1'b1);
      check_eq("h_full_511", 128'(load_full), 128'(0));
      load(1, 511, 16'h7000, 1'b1);
      check_eq("h_full_512", 128'(load_full), 128'(1));

      // swap wins over restart
      swap = 1'b1; restart = 1'b1;
      tick();
      swap = 1'b0; restart = 1'b0;
      check_eq("pri_set", 128'(active_set), 128'(0));
      check_eq("pri_full", 128'(load_full), 128'(0));
      for (int k = 0; k < NB; k++) ja[k] = AW'((k * 7 + 5) % 64);
      drive_a();
      CEN = ON;
      tick();
      hold_q = expq(16'h7000);
      check_eq("pri_rd", Q, hold_q);
      CEN = OFF;
      all_a(0);
      tick();
      tick();
      check_eq("hold_q", Q, hold_q);

      // Reset wins over swap
      load(512, 0, 16'h0000, 1'b0);
      check_eq("r_full", 128'(load_full), 128'(1));
      swap = 1'b1; rst = 1'b1;
      tick();
      swap = 1'b0; rst = 1'b0;
      check_eq("rsw_set", 128'(active_set), 128'(0));
      check_eq("rsw_full", 128'(load_full), 128'(0));
      check_eq("rsw_q", Q, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
